link_init_seq: RTL

LINK_INIT_SEQ -- requirements
Module: link_init_seq

---
 rtl/link_init_pkg.sv | 21 ++
 rtl/sync_2ff.sv | 23 ++
 rtl/link_init_seq.sv | 118 +++++++++++
 3 files changed

// File: rtl/link_init_pkg.sv
// Shared types for the link bring-up sequencer: FSM state encoding and helpers.
package link_init_pkg;

    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        IDLE      = 3'd0,
        PLL_RST   = 3'd1,
        WAIT_LOCK = 3'd2,
        SETTLE    = 3'd3,
        READY     = 3'd4,
        FAULT     = 3'd5
    } state_t;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer, one chain per bit, for asynchronous lock inputs.
module sync_2ff #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] meta;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/link_init_seq.sv
// PLL reset / lock-wait / settle sequencer with bounded retries and sticky fault.
// Define LOCK_SYNC_EN to pass the lock inputs through a 2-flop synchronizer.
module link_init_seq
    import link_init_pkg::*;
#(
    parameter int N_CH      = 2,
    parameter int RST_CNT_W = 16,
    parameter int TIMEOUT_W = 20,
    parameter int SETTLE_W  = 25,
    parameter int MAX_RETRY = 3
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         wakeup,
    input  logic [N_CH-1:0]              lock,
    input  logic [N_CH-1:0]              lock_mask,
    output logic                         pll_rst,
    output logic                         n_ready,
    output logic                         fault,
    output logic [2:0]                   state,
    output logic [$clog2(MAX_RETRY+1)-1:0] retry_cnt
);

    localparam int CNT_W   = max3(RST_CNT_W, TIMEOUT_W, SETTLE_W);
    localparam int RETRY_W = $clog2(MAX_RETRY + 1);

    localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(2**RST_CNT_W - 1);
    localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(2**TIMEOUT_W - 1);
    localparam logic [CNT_W-1:0] SET_LAST = CNT_W'(2**SETTLE_W - 1);

    state_t               st;
    state_t               st_nxt;
    logic [CNT_W-1:0]     cnt;
    logic [RETRY_W-1:0]   retry_nxt;
    logic [N_CH-1:0]      lock_s;
    logic                 all_lock;
    logic                 fail;

`ifdef LOCK_SYNC_EN
    sync_2ff #(
        .W (N_CH)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (lock),
        .q   (lock_s)
    );
`else
    assign lock_s = lock;
`endif

    // Unmasked channels count as locked, so an all-zero mask is locked.
    assign all_lock = &(lock_s | ~lock_mask);
    assign state    = st;

    always_comb begin
        st_nxt    = st;
        retry_nxt = retry_cnt;
        fail      = 1'b0;
        if (!wakeup) begin
            st_nxt    = IDLE;
            retry_nxt = '0;
        end else begin
            unique case (st)
                IDLE:      st_nxt = PLL_RST;
                PLL_RST:   if (cnt == RST_LAST) st_nxt = WAIT_LOCK;
                WAIT_LOCK: begin
                    if (all_lock)           st_nxt = SETTLE;
                    else if (cnt == TO_LAST) fail  = 1'b1;
                end
                SETTLE: begin
                    if (!all_lock)           fail   = 1'b1;
                    else if (cnt == SET_LAST) st_nxt = READY;
                end
                READY:     if (!all_lock) fail = 1'b1;
                FAULT:     st_nxt = FAULT;
                default:   st_nxt = IDLE;
            endcase
            if (fail) begin
                if (retry_cnt < RETRY_W'(MAX_RETRY)) begin
                    retry_nxt = retry_cnt + RETRY_W'(1);
                    st_nxt    = PLL_RST;
                end else begin
                    st_nxt = FAULT;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st        <= IDLE;
            cnt       <= '0;
            retry_cnt <= '0;
        end else begin
            st        <= st_nxt;
            retry_cnt <= retry_nxt;
            // Time-in-state counter saturates rather than wrapping.
            if (st_nxt != st)
                cnt <= '0;
            else if (cnt != '1)
                cnt <= cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pll_rst <= 1'b1;
            n_ready <= 1'b1;
            fault   <= 1'b0;
        end else begin
            pll_rst <= (st == IDLE) || (st == PLL_RST) || (st == FAULT);
            n_ready <= (st != READY);
            fault   <= (st == FAULT);
        end
    end

endmodule
